// File: rtl/lcd_fetch.sv
// ---------------------------------------------------------------------------
// lcd_fetch
//
// Walks the character screen of an LCD controller and turns every cell into
// one row of pixels. One memory access happens per lcd_slot. A cell costs
// three slots: attribute address, font address, then font capture. The
// font-capture slot also presents the next cell's character address.
//
// Memory handshake: lcd_addr is registered and changes only on a cycle with
// lcd_slot=1. ext_rdata must carry the byte for the address that was on
// lcd_addr before that slot edge. Nothing moves on cycles without a slot.
// pix_valid and frame_start are the exception: they are single-clk pulses
// and drop on the next clk whether or not it is a slot.
//
// Ports
//   clk          50MHz master clock, the only clock
//   res_n        asynchronous active-low reset
//   lcd_slot     this clk is an LCD memory slot
//   lcd_on       display enable; low on any slot forces IDLE
//   lcd_pb0..3   font base registers (Lores0, Lores1, Hires0, Hires1)
//   lcd_sbr      screen base register, latched at frame start
//   t_1s, t_5ms  flash and grey timebases
//   ext_rdata    read data for the previously presented address
//   lcd_addr     22-bit physical fetch address
//   pix_data     cell pixels, MSB leftmost, unused bits zero
//   pix_width    0 = 6 pixels, 1 = 8 pixels
//   pix_valid    one-clk strobe qualifying pix_data/pix_width/pix_line/pix_col
//   pix_line     pixel line (0..63) of the emitted cell
//   pix_col      cell index within the line
//   frame_start  one-clk pulse with the first character address of a frame
//   fsm_state    debug view of the fetch state
// ---------------------------------------------------------------------------
module lcd_fetch (
  input  logic        clk,
  input  logic        res_n,
  input  logic        lcd_slot,
  input  logic        lcd_on,
  input  logic [12:0] lcd_pb0,
  input  logic [9:0]  lcd_pb1,
  input  logic [8:0]  lcd_pb2,
  input  logic [10:0] lcd_pb3,
  input  logic [10:0] lcd_sbr,
  input  logic        t_1s,
  input  logic        t_5ms,
  input  logic [7:0]  ext_rdata,
  output logic [21:0] lcd_addr,
  output logic [7:0]  pix_data,
  output logic        pix_width,
  output logic        pix_valid,
  output logic [5:0]  pix_line,
  output logic [6:0]  pix_col,
  output logic        frame_start,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_A_CHR = 3'd1,
    S_A_ATR = 3'd2,
    S_A_FNT = 3'd3,
    S_C_FNT = 3'd4
  } state_t;

  localparam logic [9:0] LINE_PX = 10'd640;

  state_t      state_q, state_d;

  logic [21:0] addr_q,        addr_d;
  logic [10:0] sbr_q,         sbr_d;
  logic [5:0]  line_q,        line_d;
  logic [6:0]  col_q,         col_d;
  logic [9:0]  px_q,          px_d;
  logic [7:0]  chr_q,         chr_d;
  logic [5:0]  atr_q,         atr_d;
  logic [7:0]  pix_data_q,    pix_data_d;
  logic        pix_width_q,   pix_width_d;
  logic        pix_valid_q,   pix_valid_d;
  logic [5:0]  pix_line_q,    pix_line_d;
  logic [6:0]  pix_col_q,     pix_col_d;
  logic        frame_start_q, frame_start_d;

  // Character address of cell (line, col): eight pixel lines share one
  // 256-byte row of char/attr pairs.
  function automatic logic [21:0] chr_addr(input logic [10:0] sbr,
                                           input logic [5:0]  line,
                                           input logic [6:0]  col);
    return {sbr, 11'b0} + {11'b0, line[5:3], 8'b0} + {14'b0, col, 1'b0};
  endfunction

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (lcd_slot) begin
      if (!lcd_on) begin
        state_d = S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE:  state_d = S_A_CHR;
          S_A_CHR: state_d = S_A_ATR;
          S_A_ATR: state_d = S_A_FNT;
          S_A_FNT: state_d = S_C_FNT;
          // C_FNT already presented the next char address, so skip A_CHR.
          S_C_FNT: state_d = S_A_ATR;
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Font address. The attribute byte arrives on ext_rdata in the same slot
  // that must present the font address, so decode straight from ext_rdata.
  // -------------------------------------------------------------------------
  logic [8:0]  code;
  logic [9:0]  code_ext;
  logic [2:0]  font_l;
  logic [8:0]  off_lo0;
  logic [9:0]  off_hi1;
  logic [21:0] font_addr;

  always_comb begin
    code      = {ext_rdata[0], chr_q};
    code_ext  = {1'b0, code};
    font_l    = line_q[2:0];
    off_lo0   = 9'd0;
    off_hi1   = 10'd0;
    font_addr = 22'd0;
    if (ext_rdata[5]) begin
      // A 9-bit code never reaches 0x300. The Hires1 window is still decoded
      // so the address map stays complete if the code widens.
      if (code_ext < 10'h300) begin
        font_addr = {lcd_pb2, 13'b0} + {10'b0, code, 3'b0} + {19'b0, font_l};
      end else begin
        off_hi1   = code_ext - 10'h300;
        font_addr = {lcd_pb3, 11'b0} + {9'b0, off_hi1, 3'b0} + {19'b0, font_l};
      end
    end else begin
      if (code < 9'h1C0) begin
        font_addr = {lcd_pb1, 12'b0} + {10'b0, code, 3'b0} + {19'b0, font_l};
      end else begin
        off_lo0   = code - 9'h1C0;
        font_addr = {lcd_pb0, 9'b0} + {10'b0, off_lo0, 3'b0} + {19'b0, font_l};
      end
    end
  end

  // -------------------------------------------------------------------------
  // Pixel formation for the cell whose font byte is on ext_rdata. The
  // modifiers apply in a fixed order: underline, reverse, flash, grey.
  // -------------------------------------------------------------------------
  logic       a_und, a_gry, a_fls, a_rev, a_hrs;
  logic [7:0] used_mask;
  logic [7:0] pix_next;

  always_comb begin
    a_und     = atr_q[1];
    a_gry     = atr_q[2];
    a_fls     = atr_q[3];
    a_rev     = atr_q[4];
    a_hrs     = atr_q[5];
    used_mask = a_hrs ? 8'hFF : 8'hFC;
    pix_next  = a_hrs ? ext_rdata : {ext_rdata[5:0], 2'b00};
    if (a_und && !a_hrs && (line_q[2:0] == 3'd7)) pix_next = 8'hFC;
    if (a_rev)                                     pix_next = pix_next ^ used_mask;
    if (a_fls && !t_1s)                            pix_next = 8'h00;
    if (a_gry && t_5ms)                            pix_next = 8'h00;
    pix_next = pix_next & used_mask;
  end

  // -------------------------------------------------------------------------
  // Cell advance: where the next cell sits once the current one is emitted.
  // -------------------------------------------------------------------------
  logic [9:0]  px_sum;
  logic        eol;
  logic        eof;
  logic [5:0]  nxt_line;
  logic [6:0]  nxt_col;
  logic [9:0]  nxt_px;
  logic [10:0] nxt_sbr;

  always_comb begin
    px_sum   = px_q + (a_hrs ? 10'd8 : 10'd6);
    eol      = (px_sum >= LINE_PX) || (col_q == 7'd127);
    eof      = eol && (line_q == 6'd63);
    nxt_line = line_q;
    nxt_col  = col_q + 7'd1;
    nxt_px   = px_sum;
    nxt_sbr  = sbr_q;
    if (eol) begin
      nxt_col  = 7'd0;
      nxt_px   = 10'd0;
      nxt_line = line_q + 6'd1;
      if (eof) begin
        nxt_line = 6'd0;
        nxt_sbr  = lcd_sbr;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output / datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    addr_d        = addr_q;
    sbr_d         = sbr_q;
    line_d        = line_q;
    col_d         = col_q;
    px_d          = px_q;
    chr_d         = chr_q;
    atr_d         = atr_q;
    pix_data_d    = pix_data_q;
    pix_width_d   = pix_width_q;
    pix_line_d    = pix_line_q;
    pix_col_d     = pix_col_q;
    pix_valid_d   = 1'b0;
    frame_start_d = 1'b0;

    if (lcd_slot) begin
      if (!lcd_on) begin
        // Any partially fetched cell is simply dropped.
        addr_d = 22'd0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            addr_d = 22'd0;
            sbr_d  = lcd_sbr;
            line_d = 6'd0;
            col_d  = 7'd0;
            px_d   = 10'd0;
          end
          S_A_CHR: begin
            addr_d = chr_addr(sbr_q, line_q, col_q);
          end
          S_A_ATR: begin
            chr_d  = ext_rdata;
            addr_d = addr_q + 22'd1;
          end
          S_A_FNT: begin
            atr_d  = ext_rdata[5:0];
            addr_d = font_addr;
          end
          S_C_FNT: begin
            pix_data_d    = pix_next;
            pix_width_d   = a_hrs;
            pix_line_d    = line_q;
            pix_col_d     = col_q;
            pix_valid_d   = 1'b1;
            line_d        = nxt_line;
            col_d         = nxt_col;
            px_d          = nxt_px;
            sbr_d         = nxt_sbr;
            frame_start_d = eof;
            addr_d        = chr_addr(nxt_sbr, nxt_line, nxt_col);
          end
          default: begin
            addr_d = 22'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      addr_q        <= 22'd0;
      sbr_q         <= 11'd0;
      line_q        <= 6'd0;
      col_q         <= 7'd0;
      px_q          <= 10'd0;
      chr_q         <= 8'd0;
      atr_q         <= 6'd0;
      pix_data_q    <= 8'd0;
      pix_width_q   <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_line_q    <= 6'd0;
      pix_col_q     <= 7'd0;
      frame_start_q <= 1'b0;
    end else begin
      addr_q        <= addr_d;
      sbr_q         <= sbr_d;
      line_q        <= line_d;
      col_q         <= col_d;
      px_q          <= px_d;
      chr_q         <= chr_d;
      atr_q         <= atr_d;
      pix_data_q    <= pix_data_d;
      pix_width_q   <= pix_width_d;
      pix_valid_q   <= pix_valid_d;
      pix_line_q    <= pix_line_d;
      pix_col_q     <= pix_col_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign lcd_addr    = addr_q;
  assign pix_data    = pix_data_q;
  assign pix_width   = pix_width_q;
  assign pix_valid   = pix_valid_q;
  assign pix_line    = pix_line_q;
  assign pix_col     = pix_col_q;
  assign frame_start = frame_start_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_lcd_fetch.sv
// ---------------------------------------------------------------------------
// tb_lcd_fetch: directed bench for lcd_fetch. A byte-map memory answers each
// presented address. A slot arrives every third clk. All sampling happens
// 1ns after the rising edge, from the main thread.
// ---------------------------------------------------------------------------
module tb_lcd_fetch;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic res_n = 1'b0;
  always #10 clk = ~clk;

  logic        lcd_slot = 1'b0;
  logic        lcd_on = 1'b0;
  logic [12:0] lcd_pb0 = 13'h0100;
  logic [9:0]  lcd_pb1 = 10'h003;
  logic [8:0]  lcd_pb2 = 9'h000;
  logic [10:0] lcd_pb3 = 11'h020;
  logic [10:0] lcd_sbr = 11'h010;
  logic        t_1s = 1'b1;
  logic        t_5ms = 1'b0;
  logic [7:0]  ext_rdata = 8'h00;
  logic [21:0] lcd_addr;
  logic [7:0]  pix_data;
  logic        pix_width;
  logic        pix_valid;
  logic [5:0]  pix_line;
  logic [6:0]  pix_col;
  logic        frame_start;
  logic [2:0]  fsm_state;

  lcd_fetch dut (
    .clk(clk), .res_n(res_n), .lcd_slot(lcd_slot), .lcd_on(lcd_on),
    .lcd_pb0(lcd_pb0), .lcd_pb1(lcd_pb1), .lcd_pb2(lcd_pb2), .lcd_pb3(lcd_pb3),
    .lcd_sbr(lcd_sbr), .t_1s(t_1s), .t_5ms(t_5ms), .ext_rdata(ext_rdata),
    .lcd_addr(lcd_addr), .pix_data(pix_data), .pix_width(pix_width),
    .pix_valid(pix_valid), .pix_line(pix_line), .pix_col(pix_col),
    .frame_start(frame_start), .fsm_state(fsm_state)
  );

  // ---------------- memory model / slot generator ----------------
  logic [7:0] mem [int];
  logic [7:0] dflt = 8'h00;
  int         slot_cnt = 0;

  function automatic logic [7:0] rd(input logic [21:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return dflt;
  endfunction

  always @(negedge clk) begin
    slot_cnt  = (slot_cnt == 2) ? 0 : slot_cnt + 1;
    lcd_slot  = (slot_cnt == 0);
    ext_rdata = rd(lcd_addr);
  end

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_err = 0;
  int pix_cnt = 0;
  int fs_cnt = 0;
  int cells_cur = 0, cells_last = 0;
  int colmax_cur = 0, colmax_last = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver / monitor tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (pix_valid) begin
      pix_cnt++;
      if (pix_col == 7'd0) begin
        cells_last  = cells_cur;
        colmax_last = colmax_cur;
        cells_cur   = 0;
        colmax_cur  = 0;
      end
      cells_cur++;
      if (int'(pix_col) > colmax_cur) colmax_cur = int'(pix_col);
    end
    if (frame_start) fs_cnt++;
  endtask

  task automatic step_slot();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!lcd_slot && n < 10);
    if (!lcd_slot) check("slot_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_pix_at(input string tag, input int line, input int col, input int budget);
    logic hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick();
      if (pix_valid && int'(pix_line) == line && int'(pix_col) == col) hit = 1'b1;
    end
    check(tag, {31'd0, hit}, 32'd1);
  endtask

  task automatic wait_pix(input string tag, input int budget);
    logic hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick();
      if (pix_valid) hit = 1'b1;
    end
    check(tag, {31'd0, hit}, 32'd1);
  endtask

  task automatic wait_fs(input string tag, input int budget);
    logic hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick();
      if (frame_start) hit = 1'b1;
    end
    check(tag, {31'd0, hit}, 32'd1);
  endtask

  task automatic restart();
    lcd_on = 1'b0;
    step_slot();
    step_slot();
  endtask

  // attribute-modifier table: attr, t_1s, t_5ms, expected pixels, width
  localparam int NA = 9;
  logic [7:0] at_attr [NA] = '{8'h18, 8'h10, 8'h00, 8'h08, 8'h18, 8'h08, 8'h04, 8'h04, 8'h30};
  logic       at_t1   [NA] = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};
  logic       at_t5   [NA] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0};
  logic [7:0] at_exp  [NA] = '{8'h00, 8'h00, 8'hFC, 8'hFC, 8'h00, 8'h00, 8'h00, 8'hFC, 8'hC0};
  logic       at_w    [NA] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};

  int pcnt0, fs0;

  initial begin
    // ---------------- reset ----------------
    repeat (4) tick();
    check("rst_addr",  {10'd0, lcd_addr}, 32'd0);
    check("rst_data",  {24'd0, pix_data}, 32'd0);
    check("rst_width", {31'd0, pix_width}, 32'd0);
    check("rst_valid", {31'd0, pix_valid}, 32'd0);
    check("rst_line",  {26'd0, pix_line}, 32'd0);
    check("rst_col",   {25'd0, pix_col}, 32'd0);
    check("rst_fs",    {31'd0, frame_start}, 32'd0);
    res_n = 1'b1;
    step_slot();
    step_slot();
    check("idle_off_addr", {10'd0, lcd_addr}, 32'd0);

    // ---------------- first cell: sbr 0x010, char 0x41, attr 0 ----------------
    mem[32'h8000] = 8'h41;
    mem[32'h8001] = 8'h00;
    mem[32'h3208] = 8'h2D;
    lcd_on = 1'b1;
    step_slot();
    check("c1_idle_addr", {10'd0, lcd_addr}, 32'h0);
    step_slot();
    check("c1_chr_addr", {10'd0, lcd_addr}, 32'h008000);
    step_slot();
    check("c1_atr_addr", {10'd0, lcd_addr}, 32'h008001);
    step_slot();
    check("c1_fnt_addr", {10'd0, lcd_addr}, 32'h003208);
    step_slot();
    check("c1_valid", {31'd0, pix_valid}, 32'd1);
    check("c1_data",  {24'd0, pix_data}, 32'hB4);
    check("c1_width", {31'd0, pix_width}, 32'd0);
    check("c1_line",  {26'd0, pix_line}, 32'd0);
    check("c1_col",   {25'd0, pix_col}, 32'd0);
    check("c1_next_chr", {10'd0, lcd_addr}, 32'h008002);
    tick();
    check("c1_valid_pulse", {31'd0, pix_valid}, 32'd0);
    // non-slot cycles hold the address
    check("c1_hold_addr", {10'd0, lcd_addr}, 32'h008002);

    // ---------------- lores line length, then hires cell at line 3 ----------------
    restart();
    lcd_on = 1'b1;
    wait_pix_at("lo_l1_reach", 1, 0, 6000);
    check("lo_cells", cells_last, 32'd107);
    check("lo_colmax", colmax_last, 32'd106);
    mem[32'h8002] = 8'h42;
    mem[32'h8003] = 8'h21;
    mem[32'h2A13] = 8'hA5;
    lcd_pb2 = 9'h001;
    wait_pix_at("hr_l3_reach", 3, 0, 6000);
    step_slot();
    check("hr_atr_addr", {10'd0, lcd_addr}, 32'h008003);
    step_slot();
    check("hr_fnt_addr", {10'd0, lcd_addr}, 32'h002A13);
    step_slot();
    check("hr_valid", {31'd0, pix_valid}, 32'd1);
    check("hr_data",  {24'd0, pix_data}, 32'hA5);
    check("hr_width", {31'd0, pix_width}, 32'd1);
    check("hr_line",  {26'd0, pix_line}, 32'd3);
    check("hr_col",   {25'd0, pix_col}, 32'd1);

    // ---------------- attribute modifiers ----------------
    restart();
    mem.delete();
    dflt = 8'h00;
    mem[32'h3000] = 8'h3F;
    mem[32'h2000] = 8'h3F;
    for (int k = 0; k < NA; k++) mem[32'h8001 + 2 * k] = at_attr[k];
    t_1s = at_t1[0];
    t_5ms = at_t5[0];
    lcd_on = 1'b1;
    for (int k = 0; k < NA; k++) begin
      wait_pix($sformatf("at%0d_seen", k), 60);
      check($sformatf("at%0d_data", k), {24'd0, pix_data}, {24'd0, at_exp[k]});
      check($sformatf("at%0d_width", k), {31'd0, pix_width}, {31'd0, at_w[k]});
      if (k + 1 < NA) begin
        t_1s = at_t1[k + 1];
        t_5ms = at_t5[k + 1];
      end
    end
    t_1s = 1'b1;
    t_5ms = 1'b0;

    // ---------------- lcd_on dropped during A_FNT ----------------
    restart();
    lcd_on = 1'b1;
    step_slot();
    step_slot();
    step_slot();
    check("off_pre_addr", {10'd0, lcd_addr}, 32'h008001);
    lcd_on = 1'b0;
    pcnt0 = pix_cnt;
    step_slot();
    check("off_addr",  {10'd0, lcd_addr}, 32'd0);
    check("off_valid", {31'd0, pix_valid}, 32'd0);
    repeat (6) step_slot();
    check("off_no_pix", pix_cnt - pcnt0, 32'd0);
    lcd_sbr = 11'h020;
    lcd_on = 1'b1;
    step_slot();
    step_slot();
    check("on_first_addr", {10'd0, lcd_addr}, 32'h010000);

    // ---------------- full frame, all hires ----------------
    restart();
    mem.delete();
    dflt = 8'h20;
    lcd_on = 1'b1;
    step_slot();
    lcd_sbr = 11'h040;
    fs0 = fs_cnt;
    wait_pix_at("fr_l1_reach", 1, 0, 2000);
    check("hi_cells", cells_last, 32'd80);
    check("hi_colmax", colmax_last, 32'd79);
    wait_pix_at("fr_l63_reach", 63, 0, 60000);
    check("fr_old_sbr_addr", {10'd0, lcd_addr}, 32'h010702);
    check("fr_no_early_fs", fs_cnt - fs0, 32'd0);
    wait_fs("fr_fs_seen", 2000);
    check("fr_fs_addr", {10'd0, lcd_addr}, 32'h020000);
    check("fr_fs_line", {26'd0, pix_line}, 32'd63);
    check("fr_fs_col",  {25'd0, pix_col}, 32'd79);
    check("fr_fs_valid", {31'd0, pix_valid}, 32'd1);
    tick();
    check("fr_fs_pulse", {31'd0, frame_start}, 32'd0);
    wait_pix("fr_wrap_pix", 60);
    check("fr_wrap_line", {26'd0, pix_line}, 32'd0);
    check("fr_wrap_col",  {25'd0, pix_col}, 32'd0);
    check("fr_wrap_next", {10'd0, lcd_addr}, 32'h020002);
    check("fr_fs_once", fs_cnt - fs0, 32'd1);

    // ---------------- asynchronous reset mid-frame, then restart ----------------
    #3 res_n = 1'b0;
    #1;
    check("arst_addr", {10'd0, lcd_addr}, 32'd0);
    check("arst_col",  {25'd0, pix_col}, 32'd0);
    check("arst_state", {29'd0, fsm_state}, 32'd0);
    #2 res_n = 1'b1;
    step_slot();
    check("rr_idle_addr", {10'd0, lcd_addr}, 32'd0);
    step_slot();
    check("rr_first_addr", {10'd0, lcd_addr}, 32'h020000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_fetch.md
LCD_FETCH -- requirements
Module: lcd_fetch

Interface
REQ-001 SHALL have port clk, input, 1, 50MHz master clock, the only clock.
REQ-002 SHALL have port res_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port lcd_slot, input, 1, this clk cycle is an LCD memory slot (one per 3.3MHz phase cycle).
REQ-004 SHALL have port lcd_on, input, 1, display enable (COM bit 0).
REQ-005 SHALL have ports lcd_pb0[12:0], lcd_pb1[9:0], lcd_pb2[8:0], lcd_pb3[10:0], inputs, font base registers (Lores0, Lores1, Hires0, Hires1).
REQ-006 SHALL have port lcd_sbr, input, 11, screen base register.
REQ-007 SHALL have ports t_1s and t_5ms, inputs, 1 each, flash and grey timebases.
REQ-008 SHALL have port ext_rdata, input, 8, memory read data for the address presented at the previous lcd_slot.
REQ-009 SHALL have port lcd_addr, output, 22, physical fetch address.
REQ-010 SHALL have ports pix_data (8), pix_width (1: 0=6px, 1=8px), pix_valid (1), outputs, emitted cell pixels, MSB leftmost.
REQ-011 SHALL have ports pix_line (6), pix_col (7), frame_start (1), outputs, current pixel line, cell index, and start-of-frame pulse.

Function
REQ-012 SHALL update lcd_addr and sample ext_rdata only in cycles where lcd_slot=1; all other cycles hold state.
REQ-013 SHALL implement FSM IDLE, A_CHR, A_ATR, A_FNT, C_FNT, advancing one state per lcd_slot.
REQ-014 IDLE: lcd_addr=0, no emission; leaves to A_CHR on a slot with lcd_on=1, latching lcd_sbr, line=0, col=0, px=0.
REQ-015 A_CHR: present char address = {sbr_latched, 11'b0} + line[5:3]*256 + col*2.
REQ-016 A_ATR: capture char byte, present char address + 1.
REQ-017 A_FNT: capture attribute byte (bit0 code[8], bit1 UND, bit2 GRY, bit3 FLS, bit4 REV, bit5 HRS); present font address.
REQ-018 Font address, code=9-bit char, l=line[2:0]: HRS=1, code<0x300 -> {pb2,13'b0}+code*8+l; HRS=1, code>=0x300 -> {pb3,11'b0}+(code-0x300)*8+l; HRS=0, code<0x1C0 -> {pb1,12'b0}+code*8+l; HRS=0, code>=0x1C0 -> {pb0,9'b0}+(code-0x1C0)*8+l.
REQ-019 C_FNT: capture font byte, assert pix_valid for exactly one clk with pix_line/pix_col of that cell, and simultaneously present next cell's char address (acts as A_CHR), then go to A_ATR.
REQ-020 Pixel formation, in order: lores p={font[5:0],2'b00}, width 0; hires p=font, width 1; UND and lores and l=7 -> p=8'hFC; REV -> invert used bits; FLS and t_1s=0 -> all used bits 0; GRY and t_5ms=1 -> all used bits 0; unused bits always 0.
REQ-021 Cell advance: px += 6 or 8; line ends when px>=640 or col=127; then col=0, px=0, line+1.
REQ-022 Frame end: after line 63 completes, line wraps to 0, sbr relatched, frame_start pulses one clk coincident with the first char address of the new frame.
REQ-023 lcd_on=0 sampled on any slot SHALL return to IDLE on that slot; any pending cell is discarded, no pix_valid.
REQ-024 pb registers SHALL be read live at A_FNT; sbr changes take effect only at frame start.
REQ-025 Address arithmetic SHALL be 22-bit modulo 2^22 with no carry out.

Reset
REQ-026 On res_n=0, FSM=IDLE, lcd_addr=0, pix_data=0, pix_width=0, pix_valid=0, pix_line=0, pix_col=0, frame_start=0, px=0, sbr_latched=0, asynchronously.
REQ-027 Reset release mid-frame SHALL restart at line 0, col 0 on the first slot with lcd_on=1.

Verification
REQ-028 sbr=11'h010, lcd_on=1, char 0x41 attr 0x00 -> addrs 0x008000, 0x008001, {pb1,12'b0}+0x208; pix_valid, width 0.
REQ-029 attr 0x21 (HRS), code 0x142, line 3, pb2=9'h001 -> font addr 0x002A13; font 0xA5 -> pix_data 0xA5, width 1.
REQ-030 All lores cells -> 107 cells/line (px reaches 642), col 0..106; all hires -> 80 cells, col 0..79.
REQ-031 REV|FLS attr, font 0x3F, t_1s=1 -> pix_data 8'h00; t_1s=0 -> 8'h00; REV only -> 8'h00; no attr -> 8'hFC.
REQ-032 lcd_on dropped during A_FNT -> IDLE next slot, no pix_valid, lcd_addr=0; re-enable -> first addr = {sbr,11'b0}.
REQ-033 Run 64 lines -> frame_start pulses once, pix_line wraps 63->0, new sbr value used only after the pulse.
